// File: rtl/led_matrix_if.sv
// Host-side write/swap port and matrix drive bundle for led_matrix_scanner.
interface led_matrix_if #(
  parameter int unsigned COLS = 5,
  parameter int unsigned ROWS = 7,
  parameter int unsigned CW   = 3
) ();

  logic            wr_en;
  logic [CW-1:0]   wr_col;
  logic [ROWS-1:0] wr_data;
  logic            swap_req;
  logic            swap_ack;
  logic            frame_start;
  logic [COLS-1:0] mat_col;
  logic [ROWS-1:0] mat_row;

  // Host / bench side
  modport master (
    output wr_en, wr_col, wr_data, swap_req,
    input  swap_ack, frame_start, mat_col, mat_row
  );

  // Scanner side
  modport slave (
    input  wr_en, wr_col, wr_data, swap_req,
    output swap_ack, frame_start, mat_col, mat_row
  );

endinterface

// File: rtl/led_matrix_scanner.sv
// Double-buffered LED dot-matrix column scanner. The host fills the back bank;
// a requested swap is deferred to the frame boundary so a frame is never torn.
module led_matrix_scanner #(
  parameter int unsigned COLS  = 5,
  parameter int unsigned ROWS  = 7,
  parameter int unsigned CW    = 3,
  parameter int unsigned DIV   = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic         clk,
  input  logic         rst,
  led_matrix_if.slave  bus
);

  localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0]   div_cnt;
  logic [CIW-1:0]  col_idx;
  logic            front;
  logic            pending;
  logic            ack_arm;
  logic [ROWS-1:0] mem [2][COLS];

  logic            slot_end_c;
  logic            frame_end_c;
  logic            frame_head_c;
  logic            do_swap_c;
  logic            blank_c;
  logic [COLS-1:0] strobe_c;
  logic [ROWS-1:0] row_c;

  assign slot_end_c   = (div_cnt == DW'(DIV - 1));
  assign frame_end_c  = slot_end_c && (col_idx == CIW'(COLS - 1));
  assign frame_head_c = (div_cnt == '0) && (col_idx == '0);
  // A request arriving on the boundary cycle itself still makes this frame's swap
  assign do_swap_c    = frame_end_c && (pending || bus.swap_req);

  // Leading blank cycles of each column slot; none when BLANK is zero
  generate
    if (BLANK == 0) begin : g_noblank
      assign blank_c = 1'b0;
    end else begin : g_blank
      assign blank_c = (div_cnt < DW'(BLANK));
    end
  endgenerate

  // Column strobe and row pattern for the current counter position
  always_comb begin
    strobe_c = '1;
    row_c    = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_idx == CIW'(c)) begin
        strobe_c[COLS-1-c] = 1'b0;
        row_c              = mem[front][c];
      end
    end
    if (blank_c) begin
      strobe_c = '1;
      row_c    = '0;
    end
  end

  // Slot divider and column index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      col_idx <= '0;
    end else if (slot_end_c) begin
      div_cnt <= '0;
      col_idx <= (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + CIW'(1);
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Sticky swap request, front pointer, and ack arming for the next frame head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front   <= 1'b0;
      pending <= 1'b0;
      ack_arm <= 1'b0;
    end else begin
      if (do_swap_c) begin
        front   <= ~front;
        pending <= 1'b0;
      end else if (bus.swap_req) begin
        pending <= 1'b1;
      end
      if (do_swap_c) begin
        ack_arm <= 1'b1;
      end else if (frame_head_c) begin
        ack_arm <= 1'b0;
      end
    end
  end

  // Back-bank writes; out-of-range columns match no entry and are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < COLS; c++) begin
          mem[b][c] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (bus.wr_en && (bus.wr_col == CW'(c))) begin
          mem[~front][c] <= bus.wr_data;
        end
      end
    end
  end

  // Registered matrix drive and frame/swap markers, one clock behind the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mat_col     <= '1;
      bus.mat_row     <= '0;
      bus.frame_start <= 1'b0;
      bus.swap_ack    <= 1'b0;
    end else begin
      bus.mat_col     <= strobe_c;
      bus.mat_row     <= row_c;
      bus.frame_start <= frame_head_c;
      bus.swap_ack    <= frame_head_c && ack_arm;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: a DIV=4/BLANK=1 instance and a DIV=1/BLANK=0 instance.
module tb_led_matrix_scanner;

  typedef logic [6:0] img_t [5];

  typedef struct {
    logic       we;
    logic [2:0] wcol;
    logic [6:0] wdata;
    logic       sreq;
    logic [4:0] exp_col;
    logic [6:0] exp_row;
    logic       exp_fs;
    logic       exp_ack;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  led_matrix_if #(.COLS(5), .ROWS(7), .CW(3)) bus1 ();
  led_matrix_if #(.COLS(5), .ROWS(7), .CW(3)) bus2 ();

  led_matrix_scanner #(.COLS(5), .ROWS(7), .CW(3), .DIV(4), .BLANK(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  led_matrix_scanner #(.COLS(5), .ROWS(7), .CW(3), .DIV(1), .BLANK(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected strobe for the DIV=4, BLANK=1 instance at scan position p
  function automatic logic [4:0] m_col(input int p);
    int c;
    int d;
    c = (p % 20) / 4;
    d = p % 4;
    if (d < 1) return 5'b11111;
    return ~(5'b10000 >> c);
  endfunction

  function automatic logic [6:0] m_row(input int p, input img_t img);
    int c;
    int d;
    c = (p % 20) / 4;
    d = p % 4;
    if (d < 1) return 7'h00;
    return img[c];
  endfunction

  task automatic idle_inputs();
    bus1.wr_en = 1'b0; bus1.wr_col = 3'd0; bus1.wr_data = 7'h00; bus1.swap_req = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_col = 3'd0; bus2.wr_data = 7'h00; bus2.swap_req = 1'b0;
  endtask

  // Drive dut1 inputs for one cycle, then check its registered outputs after the edge
  task automatic step1(input string tag, input int p, input logic we, input logic [2:0] wc,
                       input logic [6:0] wd, input logic sr, input logic [4:0] ec,
                       input logic [6:0] er, input logic efs, input logic eack);
    bus1.wr_en = we; bus1.wr_col = wc; bus1.wr_data = wd; bus1.swap_req = sr;
    @(posedge clk);
    #1;
    chk($sformatf("%s p%0d mat_col", tag, p), 32'(bus1.mat_col), 32'(ec));
    chk($sformatf("%s p%0d mat_row", tag, p), 32'(bus1.mat_row), 32'(er));
    chk($sformatf("%s p%0d frame_start", tag, p), 32'(bus1.frame_start), 32'(efs));
    chk($sformatf("%s p%0d swap_ack", tag, p), 32'(bus1.swap_ack), 32'(eack));
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, " mat_col"}, 32'(bus1.mat_col), 32'h1F);
    chk({tag, " mat_row"}, 32'(bus1.mat_row), 32'h0);
    chk({tag, " frame_start"}, 32'(bus1.frame_start), 32'h0);
    chk({tag, " swap_ack"}, 32'(bus1.swap_ack), 32'h0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_blank("reset");
    chk("reset dut2 mat_col", 32'(bus2.mat_col), 32'h1F);
    rst = 1'b0;
  endtask

  img_t img1;
  img_t all7f;
  img_t img_a;
  img_t img_b;
  vec_t tv [40];

  initial begin
    img1  = '{7'h3F, 7'h4F, 7'h4D, 7'h4F, 7'h3F};
    all7f = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    img_a = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10};
    img_b = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55};

    // Image load then swap: first frame dark, second frame shows img1 with ack
    for (int i = 0; i < 40; i++) begin
      tv[i].we      = (i < 5);
      tv[i].wcol    = 3'(i % 8);
      tv[i].wdata   = (i < 5) ? img1[i] : 7'h00;
      tv[i].sreq    = (i == 5);
      tv[i].exp_col = m_col(i);
      tv[i].exp_row = (i < 20) ? 7'h00 : m_row(i, img1);
      tv[i].exp_fs  = ((i % 20) == 0);
      tv[i].exp_ack = (i == 20);
    end

    idle_inputs();
    do_reset();

    for (int i = 0; i < 40; i++) begin
      step1("t1", i, tv[i].we, tv[i].wcol, tv[i].wdata, tv[i].sreq,
            tv[i].exp_col, tv[i].exp_row, tv[i].exp_fs, tv[i].exp_ack);
    end

    // Writes without swap never reach the display
    do_reset();
    for (int p = 0; p < 60; p++) begin
      step1("t2", p, (p < 5), 3'(p % 8), 7'h7F, 1'b0, m_col(p), 7'h00, ((p % 20) == 0), 1'b0);
    end

    // Two requests in one frame give one swap at the boundary
    for (int p = 0; p < 40; p++) begin
      step1("t3", p, 1'b0, 3'd0, 7'h00, (p == 3) || (p == 12), m_col(p),
            (p < 20) ? 7'h00 : m_row(p, all7f), ((p % 20) == 0), (p == 20));
    end

    // Out-of-range writes dropped, write on swap edge visible, back keeps old front
    for (int p = 0; p < 60; p++) begin
      logic       we;
      logic [2:0] wc;
      logic [6:0] wd;
      logic [6:0] er;
      img_t       shown;
      we = 1'b0; wc = 3'd0; wd = 7'h00;
      if (p < 5) begin
        we = 1'b1; wc = 3'(p); wd = img_a[p];
      end else if (p == 5) begin
        we = 1'b1; wc = 3'd5; wd = 7'h7F;
      end else if (p == 6) begin
        we = 1'b1; wc = 3'd7; wd = 7'h7F;
      end else if (p == 19) begin
        we = 1'b1; wc = 3'd2; wd = 7'h55;
      end
      shown = img_a;
      shown[2] = 7'h55;
      if (p < 20 || p >= 40) er = m_row(p, all7f);
      else                   er = m_row(p, shown);
      step1("t4", p, we, wc, wd, (p == 7) || (p == 25), m_col(p), er,
            ((p % 20) == 0), (p == 20) || (p == 40));
    end

    // Asynchronous reset while column 2 is driven; pending request is discarded
    for (int p = 0; p < 10; p++) begin
      step1("t5pre", p, 1'b0, 3'd0, 7'h00, (p == 5), m_col(p), m_row(p, all7f),
            ((p % 20) == 0), 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_blank("t5 async");
    @(posedge clk);
    #1;
    chk_blank("t5 held");
    rst = 1'b0;
    for (int p = 0; p < 40; p++) begin
      step1("t5post", p, 1'b0, 3'd0, 7'h00, 1'b0, m_col(p), 7'h00, ((p % 20) == 0), 1'b0);
    end

    // DIV=1, BLANK=0 instance: strobe every cycle, swaps still on frame boundaries
    do_reset();
    for (int p = 0; p < 15; p++) begin
      logic [6:0] er;
      bus2.wr_en    = (p < 5);
      bus2.wr_col   = 3'(p % 8);
      bus2.wr_data  = (p < 5) ? img_b[p] : 7'h00;
      bus2.swap_req = (p == 2) || (p == 7);
      @(posedge clk);
      #1;
      er = (p >= 5 && p < 10) ? img_b[p % 5] : 7'h00;
      chk($sformatf("t6 p%0d mat_col", p), 32'(bus2.mat_col), 32'(5'(~(5'b10000 >> (p % 5)))));
      chk($sformatf("t6 p%0d mat_row", p), 32'(bus2.mat_row), 32'(er));
      chk($sformatf("t6 p%0d frame_start", p), 32'(bus2.frame_start), 32'((p % 5) == 0));
      chk($sformatf("t6 p%0d swap_ack", p), 32'(bus2.swap_ack), 32'((p == 5) || (p == 10)));
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
